// File: rtl/main_counter_pkg.sv
// Shared definitions for the multi-channel main counter: mode encodings and
// default sizing constants.
package main_counter_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int NUM_CH_DEF = 4;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_CONT    = 2'b01,
    MODE_EDGE    = 2'b10,
    MODE_CENTER  = 2'b11
  } mode_e;

endpackage

// File: rtl/main_counter_mc_counter_channel.sv
// One independent counter channel: counter, direction, sticky done and wrap pulse.
// Optional SHADOW_PERIOD_EN: period is sampled into a shadow register at cycle boundaries.
module counter_channel
  import main_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             sw_rst,
  input  logic             counter_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] period_reg,
  output logic [WIDTH-1:0] counter,
  output logic             dir,
  output logic             wrap_evt,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] per;
  logic [WIDTH-1:0] per_m1;
  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_dir;
  logic             nxt_done;
  logic             nxt_wrap;

`ifdef SHADOW_PERIOD_EN
  logic [WIDTH-1:0] shadow_q;
  assign per = shadow_q;
`else
  assign per = period_reg;
`endif

  assign per_m1 = per - ONE;

  // Comparisons use >= so a period shrunk below the current count wraps at once.
  always_comb begin
    nxt_cnt  = counter;
    nxt_dir  = dir;
    nxt_done = done;
    nxt_wrap = 1'b0;
    if (!counter_en) begin
      nxt_cnt = counter;
    end else if (done) begin
      nxt_cnt = '0;
      nxt_dir = 1'b0;
    end else begin
      case (mode_e'(mode))
        MODE_EDGE: begin
          nxt_dir = 1'b0;
          if (per == '0) begin
            nxt_cnt = '0;
          end else if (counter >= per_m1) begin
            nxt_cnt  = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_cnt = counter + ONE;
          end
        end
        MODE_CONT: begin
          nxt_dir = 1'b0;
          if (counter >= per) begin
            nxt_cnt  = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_cnt = counter + ONE;
          end
        end
        MODE_ONESHOT: begin
          nxt_dir = 1'b0;
          if (counter >= per) begin
            nxt_cnt  = '0;
            nxt_done = 1'b1;
            nxt_wrap = 1'b1;
          end else begin
            nxt_cnt = counter + ONE;
          end
        end
        MODE_CENTER: begin
          if (per == '0) begin
            nxt_cnt = '0;
            nxt_dir = 1'b0;
          end else if (!dir) begin
            if (counter >= per) begin
              nxt_cnt = per_m1;
              nxt_dir = 1'b1;
            end else begin
              nxt_cnt = counter + ONE;
            end
          end else if (counter == '0) begin
            nxt_cnt  = ONE;
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_cnt = counter - ONE;
          end
        end
        default: nxt_cnt = counter;
      endcase
    end
  end

  always_ff @(posedge slow_clk) begin
    if (rst || sw_rst) begin
      counter  <= '0;
      dir      <= 1'b0;
      wrap_evt <= 1'b0;
      done     <= 1'b0;
`ifdef SHADOW_PERIOD_EN
      shadow_q <= period_reg;
`endif
    end else begin
      counter  <= nxt_cnt;
      dir      <= nxt_dir;
      wrap_evt <= nxt_wrap;
      done     <= nxt_done;
`ifdef SHADOW_PERIOD_EN
      if (nxt_wrap) shadow_q <= period_reg;
`endif
    end
  end

endmodule

// File: rtl/main_counter_mc.sv
// Multi-channel main counter: NUM_CH independent counter_channel instances on packed buses.
// Build option SHADOW_PERIOD_EN selects boundary-synchronous period updates in each channel.
module main_counter_mc
  import main_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                    slow_clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       sw_rst,
  input  logic [NUM_CH-1:0]       counter_en,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [WIDTH*NUM_CH-1:0] period_reg,
  output logic [WIDTH*NUM_CH-1:0] counter,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       wrap_evt,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .slow_clk  (slow_clk),
      .rst       (rst),
      .sw_rst    (sw_rst[i]),
      .counter_en(counter_en[i]),
      .mode      (mode[2*i +: 2]),
      .period_reg(period_reg[WIDTH*i +: WIDTH]),
      .counter   (counter[WIDTH*i +: WIDTH]),
      .dir       (dir[i]),
      .wrap_evt  (wrap_evt[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_main_counter_mc.sv
// Scoreboard bench for main_counter_mc: directed scenarios plus random traffic
// against a per-channel behavioural model of the counting rules.
module tb_main_counter_mc;
  import main_counter_pkg::*;

  localparam int W = 16;
  localparam int N = 4;
  localparam int MASK = (1 << W) - 1;

  logic           slow_clk = 1'b0;
  logic           rst;
  logic [N-1:0]   sw_rst;
  logic [N-1:0]   counter_en;
  logic [2*N-1:0] mode;
  logic [W*N-1:0] period_reg;
  logic [W*N-1:0] counter;
  logic [N-1:0]   dir;
  logic [N-1:0]   wrap_evt;
  logic [N-1:0]   done;

  main_counter_mc #(.WIDTH(W), .NUM_CH(N)) dut (
    .slow_clk  (slow_clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .counter_en(counter_en),
    .mode      (mode),
    .period_reg(period_reg),
    .counter   (counter),
    .dir       (dir),
    .wrap_evt  (wrap_evt),
    .done      (done)
  );

  always #5 slow_clk = ~slow_clk;

  typedef struct packed {
    logic [W*N-1:0] cnt;
    logic [N-1:0]   dir;
    logic [N-1:0]   wrap;
    logic [N-1:0]   done;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  int m_cnt[N];
  int m_sh[N];
  bit m_dir[N];
  bit m_done[N];
  bit m_wrap[N];

  // Reference: next state of every channel for the inputs currently applied.
  function automatic void model_edge();
    for (int ch = 0; ch < N; ch++) begin
      int md;
      int pr;
      int p;
      md = int'(mode[2*ch +: 2]);
      pr = int'(period_reg[W*ch +: W]);
      m_wrap[ch] = 1'b0;
      if (rst || sw_rst[ch]) begin
        m_cnt[ch] = 0; m_dir[ch] = 1'b0; m_done[ch] = 1'b0; m_sh[ch] = pr;
      end else if (counter_en[ch]) begin
`ifdef SHADOW_PERIOD_EN
        p = m_sh[ch];
`else
        p = pr;
`endif
        if (m_done[ch]) begin
          m_cnt[ch] = 0; m_dir[ch] = 1'b0;
        end else if (md == 2) begin
          m_dir[ch] = 1'b0;
          if (p == 0) m_cnt[ch] = 0;
          else if (m_cnt[ch] >= p - 1) begin m_cnt[ch] = 0; m_wrap[ch] = 1'b1; end
          else m_cnt[ch] = m_cnt[ch] + 1;
        end else if (md == 1) begin
          m_dir[ch] = 1'b0;
          if (m_cnt[ch] >= p) begin m_cnt[ch] = 0; m_wrap[ch] = 1'b1; end
          else m_cnt[ch] = (m_cnt[ch] + 1) & MASK;
        end else if (md == 0) begin
          m_dir[ch] = 1'b0;
          if (m_cnt[ch] >= p) begin m_cnt[ch] = 0; m_done[ch] = 1'b1; m_wrap[ch] = 1'b1; end
          else m_cnt[ch] = m_cnt[ch] + 1;
        end else begin
          if (p == 0) begin m_cnt[ch] = 0; m_dir[ch] = 1'b0; end
          else if (!m_dir[ch]) begin
            if (m_cnt[ch] >= p) begin m_cnt[ch] = p - 1; m_dir[ch] = 1'b1; end
            else m_cnt[ch] = m_cnt[ch] + 1;
          end else if (m_cnt[ch] == 0) begin
            m_cnt[ch] = 1; m_dir[ch] = 1'b0; m_wrap[ch] = 1'b1;
          end else m_cnt[ch] = m_cnt[ch] - 1;
        end
`ifdef SHADOW_PERIOD_EN
        if (m_wrap[ch]) m_sh[ch] = pr;
`endif
      end
    end
  endfunction

  task automatic tick();
    exp_t e;
    model_edge();
    for (int ch = 0; ch < N; ch++) begin
      e.cnt[W*ch +: W] = W'(m_cnt[ch]);
      e.dir[ch]        = m_dir[ch];
      e.wrap[ch]       = m_wrap[ch];
      e.done[ch]       = m_done[ch];
    end
    sb_q.push_back(e);
    @(posedge slow_clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] md, input int p, input bit en);
    mode[2*ch +: 2]       = md;
    period_reg[W*ch +: W] = W'(p);
    counter_en[ch]        = en;
  endtask

  task automatic chk(input string name, input int ch, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s ch%0d t=%0t got %0d want %0d", name, ch, $time, act, req);
    end
  endtask

  // Monitor: every edge has one expectation queued by the driver.
  always @(posedge slow_clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int ch = 0; ch < N; ch++) begin
        chk("counter", ch, int'(counter[W*ch +: W]), int'(e.cnt[W*ch +: W]));
        chk("dir", ch, int'(dir[ch]), int'(e.dir[ch]));
        chk("wrap_evt", ch, int'(wrap_evt[ch]), int'(e.wrap[ch]));
        chk("done", ch, int'(done[ch]), int'(e.done[ch]));
      end
    end
  end

  initial begin
    int guard;
    for (int ch = 0; ch < N; ch++) begin
      m_cnt[ch] = 0; m_sh[ch] = 0; m_dir[ch] = 1'b0; m_done[ch] = 1'b0; m_wrap[ch] = 1'b0;
    end
    // Reset with every other input nonzero
    rst        = 1'b1;
    sw_rst     = '1;
    counter_en = '1;
    mode       = '1;
    period_reg = {N{16'h0007}};
    tick();
    rst    = 1'b0;
    sw_rst = '0;

    // All four modes side by side from a common restart
    set_ch(0, MODE_EDGE, 4, 1'b1);
    set_ch(1, MODE_CONT, 4, 1'b1);
    set_ch(2, MODE_ONESHOT, 4, 1'b1);
    set_ch(3, MODE_CENTER, 3, 1'b1);
    sw_rst = '1;
    tick();
    sw_rst = '0;
    for (int k = 0; k < 16; k++) tick();

    // Degenerate periods
    set_ch(0, MODE_EDGE, 1, 1'b1);
    set_ch(1, MODE_CONT, 0, 1'b1);
    set_ch(2, MODE_EDGE, 0, 1'b1);
    set_ch(3, MODE_CENTER, 0, 1'b1);
    sw_rst = '1;
    tick();
    sw_rst = '0;
    for (int k = 0; k < 4; k++) tick();
    set_ch(3, MODE_CENTER, 1, 1'b1);
    for (int k = 0; k < 5; k++) tick();

    // Disable ch0 at count 5 with P=10, then resume
    set_ch(0, MODE_EDGE, 10, 1'b1);
    sw_rst = 4'b0001;
    tick();
    sw_rst = '0;
    guard = 0;
    while (m_cnt[0] != 5 && guard < 20) begin tick(); guard++; end
    counter_en[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    counter_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // Soft reset of ch0 mid-count, others keep running
    set_ch(1, MODE_CONT, 6, 1'b1);
    set_ch(3, MODE_CENTER, 3, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    sw_rst = 4'b0001;
    tick();
    sw_rst = '0;
    for (int k = 0; k < 3; k++) tick();

    // Period shrink 10 -> 4 at count 6
    set_ch(0, MODE_EDGE, 10, 1'b1);
    sw_rst = 4'b0001;
    tick();
    sw_rst = '0;
    guard = 0;
    while (m_cnt[0] != 6 && guard < 20) begin tick(); guard++; end
    period_reg[0 +: W] = W'(4);
    for (int k = 0; k < 12; k++) tick();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int ch = 0; ch < N; ch++) begin
        sw_rst[ch]     = ($urandom_range(0, 31) == 0);
        counter_en[ch] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) mode[2*ch +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) period_reg[W*ch +: W] = W'($urandom_range(0, 12));
      end
      tick();
    end
    rst    = 1'b0;
    sw_rst = '0;

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin @(posedge slow_clk); #2; guard++; end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_counter_mc.md
Name: main_counter_mc

Overview:
Multi-channel, width-parametrised successor to the PWM timer's main counter. It holds NUM_CH independent counters clocked by the divided slow clock, and feeds the PWM and timer cores. Each channel supports four modes:
- one-shot timer
- continuous timer
- edge-aligned PWM
- center-aligned (up/down) PWM

Each channel also has its own wrap event, direction and done flags.

Parameters:
WIDTH, 16, counter and period width per channel
NUM_CH, 4, number of independent counter channels

Ports:
slow_clk  in  1  counting clock from the clock divider; all logic on its rising edge
rst  in  1  synchronous active-high reset; clears all channels
sw_rst  in  NUM_CH  per-channel synchronous software reset (ctrl soft-reset bits), active-high
counter_en  in  NUM_CH  per-channel count enable
mode  in  2*NUM_CH  per-channel mode, ch i at [2i+1:2i]: 00 one-shot timer, 01 continuous timer, 10 edge PWM, 11 center PWM
period_reg  in  WIDTH*NUM_CH  per-channel period P, ch i at [WIDTH*i +: WIDTH]
counter  out  WIDTH*NUM_CH  per-channel counter value
dir  out  NUM_CH  1 = counting down (center mode only), else 0
wrap_evt  out  NUM_CH  one-cycle pulse per completed counting cycle
done  out  NUM_CH  one-shot completion flag, sticky

Behaviour:
Reset and priority:
- Reset is synchronous and active-high, on the slow_clk rising edge; ports are slow_clk and rst.
- rst or sw_rst[i] → counter=0, dir=0, wrap_evt=0, done=0 for that channel. rst covers all channels.
- Priority: rst > sw_rst[i] > counter_en[i]=0 > counting.

Enable:
- counter_en[i]=0 → counter, dir and done hold; wrap_evt=0.
- Re-enabling resumes from the held value with no restart.

Registered outputs:
- All outputs are registered.
- wrap_evt[i] is asserted in the cycle where counter[i] first shows the post-wrap value (0, or the turn-around value in center mode).

Per-mode counting, with P = channel's effective period:
- Edge PWM (10):
  - Counts 0,1,…,P-1,0,…; wrap when counter>=P-1.
  - P=0: counter stays 0, no wrap_evt.
  - P=1: counter stays 0, wrap_evt every cycle.
- Continuous timer (01):
  - Counts 0..P, then 0; wrap when counter>=P.
  - P=0: counter stays 0, wrap_evt every cycle.
- One-shot timer (00):
  - Counts 0..P. On the edge after counter==P, counter goes to 0, done goes to 1 and wrap_evt pulses once.
  - While done=1, counter stays 0 and no further wrap_evt is produced.
  - done is cleared only by rst or sw_rst[i].
  - A mode change leaves done set; the channel does not count until reset.
- Center PWM (11):
  - Counts up 0..P, then down P-1..0, then up again. dir=1 while descending.
  - At counter==P with dir=0: next value P-1, dir becomes 1.
  - At counter==0 with dir=1: next value 1, dir becomes 0, wrap_evt pulses. Period is 2P cycles.
  - P=0: stays 0, dir=0, no wrap_evt.
  - counter>P while ascending: next value P-1, dir becomes 1.

Mode and period changes, arithmetic:
- A mode or period change mid-count takes effect on the next edge.
- Comparisons use >= so a shrunk period wraps immediately and never overruns.
- Arithmetic is unsigned, WIDTH bits. P = 2^WIDTH-1 in continuous mode wraps naturally; no overflow flag.
- Channels are fully independent; simultaneous wraps on several channels are all reported in the same cycle.

Optional Feature:
SHADOW_PERIOD_EN
- Defined:
  - Each channel keeps a shadow copy of period_reg, loaded on rst, on sw_rst[i], and on the same edge that produces a wrap (or done).
  - Comparisons use only the shadow copy, so writes take effect at the cycle boundary (glitch-free PWM).
- Undefined:
  - period_reg is compared directly, with the immediate-effect rules above.

Decomposition:
- Package main_counter_pkg holds:
  - mode encodings MODE_ONESHOT=2'b00, MODE_CONT=2'b01, MODE_EDGE=2'b10, MODE_CENTER=2'b11
  - the default WIDTH/NUM_CH constants
- Sub-module counter_channel implements one channel (counter, dir, done, wrap_evt, optional shadow register). main_counter_mc is a generate loop over NUM_CH instances plus slicing of the packed buses.

Test Plan:
- Reset: drive all inputs to nonzero values with rst=1 for one edge → every counter=0, dir=0, done=0, wrap_evt=0.
- Edge PWM, ch0, P=4 → 0,1,2,3,0,1,2,3; wrap_evt high exactly in the cycles showing 0 after 3.
- Continuous timer on ch1 with P=4 while ch0 runs edge PWM with P=4 → ch1 shows 0..4 repeated, ch0 shows 0..3 repeated; no cross-channel interference.
- One-shot, ch2, P=4 → 0,1,2,3,4, then 0 held for ≥5 cycles; done=1 from the first held 0; one wrap_evt.
- Center PWM, ch3, P=3 → 0,1,2,3,2,1,0,1,…; dir=1 during 2,1,0; wrap_evt when 1 follows 0.
- Corner case: disable ch0 at counter=5 (P=10) → counter holds 5 for 5 cycles.
- Corner case: sw_rst[0] mid-count → ch0 reads 0 next cycle, other channels unaffected.
- Corner case: with SHADOW_PERIOD_EN, change P from 10 to 4 at count 6 → counts to 9 before switching to the 0..3 cycle.
